// File: rtl/param_rand_matrix_gen_pkg.sv
// Shared definitions for the random matrix generator.
// Contents:
//   state_t           - controller states (IDLE, GEN, DONE)
//   MODE_*            - element mode codes driven on the mode input
//   SEED_DEFAULT      - LFSR reset/fallback seed
//   lfsr_taps()       - feedback tap mask for a given LFSR width
package param_rand_matrix_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_UNIFORM = 2'd0;
  localparam logic [1:0] MODE_ZERO    = 2'd1;
  localparam logic [1:0] MODE_IDENT   = 2'd2;
  localparam logic [1:0] MODE_SPARSE  = 2'd3;

  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

  // Tap mask (bit i set = bit i feeds the XOR). 16 bits uses taps
  // 15,13,12,10; a few other widths are provided for reuse.
  function automatic logic [63:0] lfsr_taps(input int w);
    logic [63:0] m;
    case (w)
      8:       m = 64'h0000_0000_0000_00B8;
      16:      m = 64'h0000_0000_0000_B400;
      32:      m = 64'h0000_0000_8020_0003;
      default: m = (64'd1 << (w - 1)) | (64'd1 << (w - 2));
    endcase
    return m;
  endfunction

endpackage

// File: rtl/param_rand_matrix_gen_lfsr_step.sv
// lfsr_step: Fibonacci LFSR with advance enable and seed load.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset (loads SEED_RST)
//   adv_i       - shift one step this cycle
//   load_i      - load seed_i this cycle (takes priority over adv_i)
//   seed_i      - seed value; a zero seed loads SEED_RST instead, since
//                 the all-zero state would lock the LFSR
//   lfsr_o      - current register value
module lfsr_step
  import param_rand_matrix_gen_pkg::*;
#(
  parameter int              W        = 16,
  parameter logic [W-1:0]    SEED_RST = W'(SEED_DEFAULT)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         adv_i,
  input  logic         load_i,
  input  logic [W-1:0] seed_i,
  output logic [W-1:0] lfsr_o
);

  localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

  logic [W-1:0] lfsr_q, lfsr_d;
  logic         fb;

  assign fb = ^(lfsr_q & TAPS);

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = (seed_i == '0) ? SEED_RST : seed_i;
    end else if (adv_i) begin
      lfsr_d = {lfsr_q[W-2:0], fb};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= SEED_RST;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/param_rand_matrix_gen.sv
// param_rand_matrix_gen: streams count matrices of dim_m x dim_n signed
// elements in row-major order over a valid/ready output.
// Ports:
//   clk, rst_n             - clock, synchronous active-low reset
//   start, abort           - job request (IDLE only) / job termination
//   mode, dim_m, dim_n,
//   count, elem_min/max    - job configuration, latched on start
//   seed_load, seed        - LFSR seed load (IDLE only)
//   out_valid, out_ready   - output handshake
//   out_data, out_row,
//   out_col, out_mat       - element value and position
//   out_last_elem/mat      - last element of matrix / final matrix
//   busy, done, err        - status; done and err are one-cycle pulses
//   state_dbg              - current controller state
//
// Handshake: a beat transfers on a rising edge where out_valid and
// out_ready are both high and abort is low. While out_valid is high and no
// transfer happens, every out_* signal holds, because outputs are decoded
// only from registers that change on a transfer.
module param_rand_matrix_gen
  import param_rand_matrix_gen_pkg::*;
#(
  parameter int                 DATA_W   = 8,
  parameter int                 DIM_W    = 3,
  parameter int                 CNT_W    = 4,
  parameter int                 LFSR_W   = 16,
  parameter logic [LFSR_W-1:0]  SEED_RST = LFSR_W'(SEED_DEFAULT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [1:0]               mode,
  input  logic [DIM_W-1:0]         dim_m,
  input  logic [DIM_W-1:0]         dim_n,
  input  logic [CNT_W-1:0]         count,
  input  logic signed [DATA_W-1:0] elem_min,
  input  logic signed [DATA_W-1:0] elem_max,
  input  logic                     seed_load,
  input  logic [LFSR_W-1:0]        seed,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [DIM_W-1:0]         out_row,
  output logic [DIM_W-1:0]         out_col,
  output logic [CNT_W-1:0]         out_mat,
  output logic                     out_last_elem,
  output logic                     out_last_mat,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output state_t                   state_dbg
);

  state_t state_q, state_d;

  logic [1:0]               mode_q, mode_d;
  logic [DIM_W-1:0]         dim_m_q, dim_m_d, dim_n_q, dim_n_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic signed [DATA_W-1:0] min_q, min_d, max_q, max_d;
  logic [DIM_W-1:0]         row_q, row_d, col_q, col_d;
  logic [CNT_W-1:0]         mat_q, mat_d;
  logic                     err_q, err_d;

  logic              in_idle, start_ok, cfg_ok, xfer, last_col, last_row, last_mat;
  logic [LFSR_W-1:0] lfsr;

  assign in_idle  = (state_q == ST_IDLE);
  assign start_ok = start && in_idle;
  // Validation looks at the inputs being latched this cycle so an accepted
  // job can present its first element on the very next cycle.
  assign cfg_ok   = (dim_m != '0) && (dim_n != '0) && (count != '0) &&
                    (elem_min <= elem_max);
  assign xfer     = out_valid && out_ready && !abort;
  assign last_col = (col_q == dim_n_q - DIM_W'(1));
  assign last_row = (row_q == dim_m_q - DIM_W'(1));
  assign last_mat = (mat_q == count_q - CNT_W'(1));

  lfsr_step #(
    .W        (LFSR_W),
    .SEED_RST (SEED_RST)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .adv_i  (xfer),
    .load_i (seed_load && in_idle),
    .seed_i (seed),
    .lfsr_o (lfsr)
  );

  // Controller state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_ok && cfg_ok) state_d = ST_GEN;
      ST_GEN: begin
        if (abort)                                      state_d = ST_IDLE;
        else if (xfer && last_col && last_row && last_mat) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Configuration, position counters and error pulse
  always_comb begin
    mode_d  = mode_q;
    dim_m_d = dim_m_q;
    dim_n_d = dim_n_q;
    count_d = count_q;
    min_d   = min_q;
    max_d   = max_q;
    row_d   = row_q;
    col_d   = col_q;
    mat_d   = mat_q;
    err_d   = start_ok && !cfg_ok;
    if (start_ok) begin
      mode_d  = mode;
      dim_m_d = dim_m;
      dim_n_d = dim_n;
      count_d = count;
      min_d   = elem_min;
      max_d   = elem_max;
    end
    if (start_ok && cfg_ok) begin
      row_d = '0;
      col_d = '0;
      mat_d = '0;
    end else if (xfer) begin
      if (!last_col) begin
        col_d = col_q + DIM_W'(1);
      end else begin
        col_d = '0;
        if (!last_row) begin
          row_d = row_q + DIM_W'(1);
        end else begin
          row_d = '0;
          mat_d = last_mat ? '0 : mat_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      dim_m_q <= '0;
      dim_n_q <= '0;
      count_q <= '0;
      min_q   <= '0;
      max_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      mat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dim_m_q <= dim_m_d;
      dim_n_q <= dim_n_d;
      count_q <= count_d;
      min_q   <= min_d;
      max_q   <= max_d;
      row_q   <= row_d;
      col_q   <= col_d;
      mat_q   <= mat_d;
      err_q   <= err_d;
    end
  end

  // Element mapping. The range is formed one bit wider than the data so
  // that a full-span range (2^DATA_W) is representable; a zero range can
  // only arise from a rejected configuration and is forced to 1 so the
  // divider never sees zero.
  logic [DATA_W:0]   range_w, range_div;
  logic [LFSR_W-1:0] r_ext, rem;
  logic [DATA_W-1:0] uni_val, elem_val;

  always_comb begin
    range_w   = {max_q[DATA_W-1], max_q} - {min_q[DATA_W-1], min_q} +
                (DATA_W+1)'(1);
    range_div = (range_w == '0) ? (DATA_W+1)'(1) : range_w;
    r_ext     = {1'b0, lfsr[LFSR_W-2:0]};
    rem       = r_ext % {{(LFSR_W-DATA_W-1){1'b0}}, range_div};
    uni_val   = min_q + rem[DATA_W-1:0];
    case (mode_q)
      MODE_UNIFORM: elem_val = uni_val;
      MODE_ZERO:    elem_val = '0;
      MODE_IDENT:   elem_val = (row_q == col_q) ? DATA_W'(1) : '0;
      MODE_SPARSE:  elem_val = (lfsr[1:0] == 2'b00) ? '0 : uni_val;
      default:      elem_val = '0;
    endcase
  end

  // Outputs are gated by out_valid so they read zero outside GEN.
  assign out_valid     = (state_q == ST_GEN);
  assign out_data      = out_valid ? elem_val : '0;
  assign out_row       = out_valid ? row_q : '0;
  assign out_col       = out_valid ? col_q : '0;
  assign out_mat       = out_valid ? mat_q : '0;
  assign out_last_elem = out_valid && last_col && last_row;
  assign out_last_mat  = out_valid && last_mat;
  assign busy          = !in_idle;
  assign done          = (state_q == ST_DONE);
  assign err           = err_q;
  assign state_dbg     = state_q;

endmodule
